// File: rtl/inst_issuer.sv
// inst_issuer: buffers host-loaded instruction words in a circular FIFO and issues them
// one at a time to a downstream controller, holding the security level for the program.
module inst_issuer #(
   parameter int INST_WIDTH = 27,
   parameter int DEPTH      = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [INST_WIDTH-1:0]    wr_inst,
   input  logic                     wr_last,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic                     start,
   input  logic [1:0]               level_in,
   input  logic                     ctrl_busy,
   output logic [INST_WIDTH-1:0]    inst,
   output logic                     inst_valid,
   output logic [1:0]               level,
   output logic                     prog_done,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, GUARD = 3'd2, WAIT = 3'd3, DONE = 3'd4;

   logic [INST_WIDTH:0] mem [DEPTH];
   logic [AW-1:0]       wptr, rptr;
   logic [2:0]          state;
   logic                last;
   logic                push, pop;

   assign wr_ready = count != FULL;
   assign push     = wr_valid && wr_ready;
   assign pop      = state == ISSUE && count != '0 && !ctrl_busy;

   always_ff @(posedge clk)
      if (push) mem[wptr] <= {wr_last, wr_inst};

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
         inst       <= '0;
         inst_valid <= 1'b0;
         level      <= '0;
         prog_done  <= 1'b0;
         overflow   <= 1'b0;
         last       <= 1'b0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         if (pop) {last, inst} <= mem[rptr];
         count      <= count + (AW+1)'(push) - (AW+1)'(pop);
         overflow   <= overflow | (wr_valid & ~wr_ready);
         inst_valid <= pop;
         // prog_done is high exactly while the FSM sits in DONE
         prog_done  <= state == WAIT && !ctrl_busy && last;
         case (state)
            IDLE: if (start) begin
               level <= level_in;
               state <= ISSUE;
            end
            ISSUE:   if (pop) state <= GUARD;
            GUARD:   state <= WAIT;
            WAIT:    if (!ctrl_busy) state <= last ? DONE : ISSUE;
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_inst_issuer.sv
// tb_inst_issuer: randomized and directed stimulus; a negedge monitor compares DUT
// outputs against a queue-based model of the FIFO and program rules.
module tb_inst_issuer;
   localparam int W = 27;
   localparam int D = 16;

   logic clk = 0, rst = 1;
   logic [W-1:0] wr_inst = '0;
   logic wr_last = 0, wr_valid = 0, start = 0, ctrl_busy = 0;
   logic [1:0] level_in = '0;
   logic wr_ready, inst_valid, prog_done, overflow;
   logic [W-1:0] inst;
   logic [1:0] level;
   logic [$clog2(D):0] count;

   always #5 clk = ~clk;

   inst_issuer #(.INST_WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .wr_inst(wr_inst), .wr_last(wr_last), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .start(start), .level_in(level_in), .ctrl_busy(ctrl_busy),
      .inst(inst), .inst_valid(inst_valid), .level(level), .prog_done(prog_done),
      .count(count), .overflow(overflow)
   );

   int n_checks = 0, n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // reference model state
   logic [W:0]   sbq [$];
   logic [W:0]   w;
   int           mcount = 0;
   logic         exp_ovf = 0;
   logic [1:0]   exp_level = '0;
   logic [W-1:0] exp_inst = '0;
   bit           in_prog = 0, done_pend = 0, rst_pend = 0, prev_busy = 0;
   int           cyc = 0, last_strobe = -100, start_cyc = 0, wr_cyc = 0, done_cyc = 0, done_cnt = 0;
   int           strobes [$];

   always @(negedge clk) begin
      cyc++;
      if (rst_pend) begin
         sbq.delete();
         mcount = 0; exp_ovf = 0; exp_level = '0; exp_inst = '0;
         in_prog = 0; done_pend = 0; rst_pend = 0; last_strobe = -100;
      end
      if (inst_valid) begin
         strobes.push_back(cyc);
         check("strobe_in_program", in_prog, 1);
         check("strobe_after_ctrl_idle", prev_busy, 0);
         check("strobe_spacing_ge3", (cyc - last_strobe) >= 3, 1);
         check("strobe_before_done", done_pend, 0);
         check("strobe_model_nonempty", sbq.size() != 0, 1);
         last_strobe = cyc;
         if (sbq.size() != 0) begin
            w = sbq.pop_front();
            exp_inst = w[W-1:0];
            done_pend = w[W];
            mcount--;
         end
      end
      check("inst", inst, exp_inst);
      if (prog_done) begin
         check("done_expected", done_pend, 1);
         check("done_after_ctrl_idle", prev_busy, 0);
         done_pend = 0;
         done_cnt++;
         done_cyc = cyc;
      end
      check("count", count, mcount);
      check("wr_ready", wr_ready, mcount != D);
      check("overflow", overflow, exp_ovf);
      check("level", level, exp_level);
      if (rst) rst_pend = 1;
      else begin
         if (wr_valid) begin
            if (mcount != D) begin
               sbq.push_back({wr_last, wr_inst});
               mcount++;
               wr_cyc = cyc;
            end else exp_ovf = 1;
         end
         if (start && !in_prog) begin
            in_prog = 1;
            exp_level = level_in;
            start_cyc = cyc;
         end
         if (prog_done) in_prog = 0;
      end
      prev_busy = ctrl_busy;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [W-1:0] d, input logic l);
      bit ok = 0;
      wr_inst = d; wr_last = l; wr_valid = 1;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         ok = wr_ready;
         tick();
      end
      wr_valid = 0;
      check("write_accepted", ok, 1);
   endtask

   task automatic write_force(input logic [W-1:0] d, input logic l);
      wr_inst = d; wr_last = l; wr_valid = 1;
      tick();
      wr_valid = 0;
   endtask

   task automatic pulse_start(input logic [1:0] lvl);
      level_in = lvl; start = 1;
      tick();
      start = 0;
   endtask

   task automatic wait_done(input int budget);
      int d0 = done_cnt;
      for (int i = 0; i < budget && done_cnt == d0; i++) tick();
      check("prog_done_seen", done_cnt != d0, 1);
   endtask

   task automatic wait_strobe();
      bit seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         tick();
         seen = inst_valid;
      end
      check("strobe_seen", seen, 1);
   endtask

   task automatic do_reset();
      rst = 1;
      tick();
      rst = 0;
      check("rst_count", count, 0);
      check("rst_wr_ready", wr_ready, 1);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_prog_done", prog_done, 0);
      check("rst_overflow", overflow, 0);
      check("rst_level", level, 0);
      check("rst_inst", inst, 0);
   endtask

   initial begin
      int d0, bcnt, len, pre;
      repeat (3) tick();
      do_reset();
      tick();

      // three-word program, controller always idle
      write(27'h1, 0); write(27'h2, 0); write(27'h3, 1);
      strobes.delete();
      pulse_start(2'd2);
      wait_done(60);
      check("t1_strobes", strobes.size(), 3);
      if (strobes.size() == 3) begin
         check("t1_first_latency", strobes[0] - start_cyc, 2);
         check("t1_gap1", strobes[1] - strobes[0], 3);
         check("t1_gap2", strobes[2] - strobes[1], 3);
         check("t1_done_gap", done_cyc - strobes[2], 2);
      end
      check("t1_level", level, 2);
      check("t1_inst_hold", inst, 27'h3);
      tick();

      // controller busy for 5 cycles after every strobe
      for (int i = 0; i < 4; i++) write(27'h10 + 27'(i), i == 3);
      strobes.delete();
      pulse_start(2'd1);
      d0 = done_cnt; bcnt = 0;
      for (int i = 0; i < 300 && done_cnt == d0; i++) begin
         tick();
         if (inst_valid) bcnt = 5;
         ctrl_busy = bcnt > 0;
         if (bcnt > 0) bcnt--;
      end
      ctrl_busy = 0;
      check("t2_done", done_cnt != d0, 1);
      check("t2_strobes", strobes.size(), 4);
      if (strobes.size() == 4)
         for (int i = 1; i < 4; i++) check("t2_gap", strobes[i] - strobes[i-1], 7);
      tick();

      // fill past capacity without starting
      for (int i = 0; i < 17; i++) write_force(27'h100 + 27'(i), i == 15);
      check("t3_count_full", count, 16);
      check("t3_wr_ready_low", wr_ready, 0);
      check("t3_overflow", overflow, 1);
      strobes.delete();
      pulse_start(2'd3);
      wait_done(200);
      check("t3_strobes", strobes.size(), 16);
      check("t3_overflow_sticky", overflow, 1);
      check("t3_inst_last", inst, 27'h10F);
      do_reset();

      // start on an empty FIFO, load later
      strobes.delete();
      pulse_start(2'd0);
      repeat (10) tick();
      check("t4_no_early_strobe", strobes.size(), 0);
      write(27'h1234567, 1);
      wait_done(40);
      check("t4_strobes", strobes.size(), 1);
      if (strobes.size() == 1) check("t4_latency", strobes[0] - wr_cyc, 2);
      check("t4_inst", inst, 27'h1234567);

      // reset while waiting on the controller
      for (int i = 0; i < 4; i++) write(27'h200 + 27'(i), i == 3);
      pulse_start(2'd2);
      wait_strobe();
      ctrl_busy = 1;
      tick();
      d0 = done_cnt;
      strobes.delete();
      do_reset();
      ctrl_busy = 0;
      repeat (10) tick();
      check("t5_no_strobe", strobes.size(), 0);
      check("t5_no_done", done_cnt, d0);
      write(27'h300, 0); write(27'h301, 1);
      pulse_start(2'd1);
      wait_done(40);
      check("t5_rerun_inst", inst, 27'h301);

      // start while in WAIT must be ignored
      for (int i = 0; i < 3; i++) write(27'h400 + 27'(i), i == 2);
      pulse_start(2'd1);
      wait_strobe();
      ctrl_busy = 1;
      tick();
      pulse_start(2'd3);
      repeat (2) tick();
      ctrl_busy = 0;
      wait_done(60);
      check("t6_level_kept", level, 1);

      // randomized programs with overlapping load and random controller activity
      for (int p = 0; p < 10; p++) begin
         len = $urandom_range(1, 6);
         pre = $urandom_range(0, len);
         for (int k = 0; k < pre; k++) write(W'($urandom), k == len - 1);
         pulse_start(2'($urandom));
         d0 = done_cnt;
         fork
            for (int k = pre; k < len; k++) begin
               repeat ($urandom_range(0, 3)) tick();
               write(W'($urandom), k == len - 1);
            end
            begin
               for (int i = 0; i < 500 && done_cnt == d0; i++) begin
                  ctrl_busy = ($urandom % 3) == 0;
                  tick();
               end
               ctrl_busy = 0;
            end
         join
         check("rand_done", done_cnt != d0, 1);
         tick();
      end

      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
